elm_param_loader: RTL and testbench

Streaming writer for the neuron configuration bus of the ELM hidden layer. Accepts a flat AXI-Stream of fixed-point words (per neuron: NUM_WEIGHT weights then one bias), and replays it as `weightValue/weightValid` and `biasValue/biasValid` strobes. Each strobe carries the `config_layer_num/config_neuron_num` address that the neurons decode. Sits between the AXI DMA/slave front end and the array of neurons.

---
 rtl/elm_loader_pkg.sv | 31 +++
 rtl/elm_param_loader.sv | 157 +++++++++++++++
 tb/tb_elm_param_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elm_loader_pkg.sv
// Shared types and width helpers for the ELM neuron parameter loader.
package elm_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WEIGHT = 2'd1,
        BIAS   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int CFG_W          = 2 * DEF_DATA_WIDTH + 1;

    function automatic int cfg_width(input int data_width);
        return 2 * data_width + 1;
    endfunction

    // Weight index runs 0..NUM_WEIGHT-1; keep at least one bit when NUM_WEIGHT is 1.
    function automatic int weight_cnt_width(input int num_weight);
        return (num_weight > 1) ? $clog2(num_weight) : 1;
    endfunction

    function automatic int neuron_cnt_width(input int num_neurons);
        return $clog2(num_neurons + 1);
    endfunction

    function automatic int layer_cnt_width(input int num_layers);
        return $clog2(num_layers + 1);
    endfunction

endpackage

// File: rtl/elm_param_loader.sv
// Replays a flat weight/bias stream as addressed neuron config strobes; optional tlast checking under LOADER_TLAST_CHECK_EN.
// Latency: strobe, value and address one cycle after the accepted beat; done one cycle after the final bias strobe.
// Backpressure: s_tready depends on state only (high in WEIGHT/BIAS); s_tvalid low stalls the FSM in place.
module elm_param_loader
    import elm_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_LAYERS  = 1,
    parameter int NUM_NEURONS = 16,
    parameter int NUM_WEIGHT  = 128
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [DATA_WIDTH-1:0]              s_tdata,
    input  logic                               s_tvalid,
    output logic                               s_tready,
    input  logic                               s_tlast,
    output logic [DATA_WIDTH-1:0]              weightValue,
    output logic                               weightValid,
    output logic [DATA_WIDTH-1:0]              biasValue,
    output logic                               biasValid,
    output logic [cfg_width(DATA_WIDTH)-1:0]   config_layer_num,
    output logic [cfg_width(DATA_WIDTH)-1:0]   config_neuron_num,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    localparam int CW  = cfg_width(DATA_WIDTH);
    localparam int WCW = weight_cnt_width(NUM_WEIGHT);
    localparam int NCW = neuron_cnt_width(NUM_NEURONS);
    localparam int LCW = layer_cnt_width(NUM_LAYERS);

    state_t         state, state_nxt;
    logic [WCW-1:0] weight_cnt;
    logic [NCW-1:0] neuron_cnt;
    logic [LCW-1:0] layer_cnt;

    logic beat;
    logic start_acc;
    logic at_last_weight;
    logic last_neuron;
    logic last_layer;
    logic final_bias;
    logic tlast_abort;
    logic tlast_miss;
    logic emit;

    assign beat           = s_tvalid & s_tready;
    assign start_acc      = (state == IDLE) & start;
    assign at_last_weight = (weight_cnt == WCW'(NUM_WEIGHT - 1));
    assign last_neuron    = (neuron_cnt == NCW'(NUM_NEURONS));
    assign last_layer     = (layer_cnt == LCW'(NUM_LAYERS));
    assign final_bias     = (state == BIAS) & last_neuron & last_layer;

`ifdef LOADER_TLAST_CHECK_EN
    assign tlast_abort = beat & s_tlast & ~final_bias;
    assign tlast_miss  = beat & final_bias & ~s_tlast;
`else
    logic unused_tlast;
    assign unused_tlast = s_tlast;
    assign tlast_abort  = 1'b0;
    assign tlast_miss   = 1'b0;
`endif

    // A beat that aborts the load is consumed but never reaches the neurons.
    assign emit = beat & ~tlast_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_tready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WEIGHT;
            end
            WEIGHT: begin
                s_tready = 1'b1;
                if (tlast_abort)                state_nxt = IDLE;
                else if (beat && at_last_weight) state_nxt = BIAS;
            end
            BIAS: begin
                s_tready = 1'b1;
                if (tlast_abort)  state_nxt = IDLE;
                else if (beat)    state_nxt = final_bias ? DONE : WEIGHT;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_cnt <= '0;
            neuron_cnt <= NCW'(1);
            layer_cnt  <= LCW'(1);
        end else if (start_acc) begin
            weight_cnt <= '0;
            neuron_cnt <= NCW'(1);
            layer_cnt  <= LCW'(1);
        end else if (emit) begin
            if (state == WEIGHT) begin
                weight_cnt <= at_last_weight ? '0 : weight_cnt + 1'b1;
            end else begin
                weight_cnt <= '0;
                if (!last_neuron) begin
                    neuron_cnt <= neuron_cnt + 1'b1;
                end else if (!last_layer) begin
                    layer_cnt  <= layer_cnt + 1'b1;
                    neuron_cnt <= NCW'(1);
                end
            end
        end
    end

    // Address registers only move on a strobe, so neurons see it stable between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weightValue       <= '0;
            weightValid       <= 1'b0;
            biasValue         <= '0;
            biasValid         <= 1'b0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            weightValid <= emit & (state == WEIGHT);
            biasValid   <= emit & (state == BIAS);
            done        <= (state == DONE);
            if (emit) begin
                config_layer_num  <= CW'(layer_cnt);
                config_neuron_num <= CW'(neuron_cnt);
                if (state == WEIGHT) weightValue <= s_tdata;
                else                 biasValue   <= s_tdata;
            end
            if (start_acc)                          busy <= 1'b1;
            else if ((state == DONE) || tlast_abort) busy <= 1'b0;
            if (start_acc)                       error <= 1'b0;
            else if (tlast_abort || tlast_miss)  error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_elm_param_loader.sv
// Randomized bench for elm_param_loader against a beat-index reference model (NUM_WEIGHT=4, NUM_NEURONS=2, NUM_LAYERS=1).
module tb_elm_param_loader;

    localparam int DW    = 16;
    localparam int NW    = 4;
    localparam int NN    = 2;
    localparam int NL    = 1;
    localparam int TOTAL = NL * NN * (NW + 1);
    localparam int CW    = 2 * DW + 1;
`ifdef LOADER_TLAST_CHECK_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] weightValue;
    logic          weightValid;
    logic [DW-1:0] biasValue;
    logic          biasValid;
    logic [CW-1:0] config_layer_num;
    logic [CW-1:0] config_neuron_num;
    logic          busy;
    logic          done;
    logic          error;

    elm_param_loader #(
        .DATA_WIDTH (DW),
        .NUM_LAYERS (NL),
        .NUM_NEURONS(NN),
        .NUM_WEIGHT (NW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .s_tdata          (s_tdata),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .s_tlast          (s_tlast),
        .weightValue      (weightValue),
        .weightValid      (weightValid),
        .biasValue        (biasValue),
        .biasValid        (biasValid),
        .config_layer_num (config_layer_num),
        .config_neuron_num(config_neuron_num),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            is_bias;
        logic [DW-1:0] val;
        int            layer;
        int            neuron;
    } strobe_t;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] img [TOTAL];
    bit            lst [TOTAL];
    strobe_t       exp_q[$];
    strobe_t       obs_q[$];
    int            exp_consumed;
    bit            exp_done;
    bit            exp_error;
    int            consumed;
    logic          err_after_start;

    int            cyc = 0;
    int            done_cnt, both_cnt, addr_chg, last_bias_cyc, done_cyc;
    logic          busy_at_done;
    logic [CW-1:0] prev_l, prev_n;

    // Observer: collects strobes and tracks address stability and done timing.
    always @(negedge clk) begin
        cyc++;
        if (weightValid && biasValid) both_cnt++;
        if (weightValid || biasValid) begin
            obs_q.push_back('{is_bias: biasValid, val: (biasValid ? biasValue : weightValue),
                              layer: int'(config_layer_num), neuron: int'(config_neuron_num)});
            if (biasValid) last_bias_cyc = cyc;
        end else if (config_layer_num !== prev_l || config_neuron_num !== prev_n) begin
            addr_chg++;
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        prev_l = config_layer_num;
        prev_n = config_neuron_num;
    end

    // Reference: beat i targets neuron (i/(NW+1))%NN+1 of layer i/((NW+1)*NN)+1; slot NW of each group is the bias.
    task automatic build_expected();
        exp_q.delete();
        exp_consumed = TOTAL;
        exp_done     = 1'b1;
        exp_error    = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            if (TLAST_EN && lst[i] && i != TOTAL - 1) begin
                exp_consumed = i + 1;
                exp_done     = 1'b0;
                exp_error    = 1'b1;
                break;
            end
            exp_q.push_back('{is_bias: ((i % (NW + 1)) == NW), val: img[i],
                              layer: i / ((NW + 1) * NN) + 1, neuron: (i / (NW + 1)) % NN + 1});
        end
        if (exp_done && TLAST_EN && !lst[TOTAL - 1]) exp_error = 1'b1;
    endtask

    function automatic int strobe_bad();
        int n = 0;
        if (obs_q.size() != exp_q.size()) n++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            if (obs_q[k].is_bias !== exp_q[k].is_bias || obs_q[k].val !== exp_q[k].val ||
                obs_q[k].layer != exp_q[k].layer || obs_q[k].neuron != exp_q[k].neuron) n++;
        end
        return n;
    endfunction

    task automatic clear_mon();
        obs_q.delete();
        done_cnt      = 0;
        both_cnt      = 0;
        addr_chg      = 0;
        last_bias_cyc = -100;
        done_cyc      = -200;
        busy_at_done  = 1'bx;
    endtask

    // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random valid.
    task automatic run_image(input int gap_mode, input int extra_start_cyc);
        int  c;
        bit  acc;
        build_expected();
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        err_after_start = error;
        consumed = 0;
        c = 0;
        while (consumed < exp_consumed && c < 500) begin
            s_tvalid = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
            s_tdata  = img[consumed];
            s_tlast  = lst[consumed];
            start    = (c == extra_start_cyc);
            @(negedge clk);
            acc = s_tvalid && s_tready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) consumed++;
            c++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic fill_image(input bit seq, input int tlast_at);
        for (int i = 0; i < TOTAL; i++) begin
            img[i] = seq ? DW'(i + 1) : DW'($urandom);
            lst[i] = (i == tlast_at);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        #12;
        checks++;
        if ({s_tready, weightValid, biasValid, busy, done, error} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b required 000000", {s_tready, weightValid, biasValid, busy, done, error});
        end
        checks++;
        if ({weightValue, biasValue, config_layer_num, config_neuron_num} !== '0) begin
            errors++; $display("FAIL reset_data: got w=%h b=%h l=%h n=%h required all zero", weightValue, biasValue, config_layer_num, config_neuron_num);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_no_consume();
        int rdy_hi = 0;
        clear_mon();
        s_tvalid = 1'b1;
        repeat (5) begin
            s_tdata = DW'($urandom);
            @(negedge clk);
            if (s_tready) rdy_hi++;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy_hi !== 0) begin errors++; $display("FAIL idle_tready: high %0d cycles required 0", rdy_hi); end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL idle_strobes: got %0d required 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        fill_image(1'b1, TOTAL - 1);
        run_image(0, -1);
        checks++;
        if (strobe_bad() !== 0) begin errors++; $display("FAIL b2b_strobes: %0d bad, %0d observed, required 0 bad of %0d", strobe_bad(), obs_q.size(), exp_q.size()); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done: got %0d pulses required 1", done_cnt); end
        checks++;
        if (done_cyc - last_bias_cyc !== 1) begin errors++; $display("FAIL b2b_done_timing: got %0d cycles after bias required 1", done_cyc - last_bias_cyc); end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done: got %b required 0", busy_at_done); end
        checks++;
        if ({error, busy, both_cnt != 0} !== 3'b000) begin errors++; $display("FAIL b2b_status: error=%b busy=%b both=%0d required 0 0 0", error, busy, both_cnt); end
    endtask

    task automatic test_gaps();
        fill_image(1'b1, TOTAL - 1);
        run_image(1, -1);
        checks++;
        if (strobe_bad() !== 0) begin errors++; $display("FAIL gaps_strobes: %0d bad, %0d observed, required 0 bad of %0d", strobe_bad(), obs_q.size(), exp_q.size()); end
        checks++;
        if (addr_chg !== 0) begin errors++; $display("FAIL gaps_addr_hold: %0d changes between strobes required 0", addr_chg); end
        checks++;
        if (done_cnt !== 1 || error !== 1'b0) begin errors++; $display("FAIL gaps_done: done=%0d error=%b required 1 0", done_cnt, error); end
    endtask

    task automatic test_tlast_early();
        fill_image(1'b1, 2);
        lst[TOTAL - 1] = 1'b1;
        run_image(0, -1);
        checks++;
        if (strobe_bad() !== 0) begin errors++; $display("FAIL early_strobes: %0d observed required %0d", obs_q.size(), exp_q.size()); end
        checks++;
        if (error !== exp_error || busy !== 1'b0) begin errors++; $display("FAIL early_status: error=%b busy=%b required %b 0", error, busy, exp_error); end
        checks++;
        if (done_cnt !== int'(exp_done)) begin errors++; $display("FAIL early_done: got %0d required %0d", done_cnt, exp_done); end
        fill_image(1'b0, TOTAL - 1);
        run_image(2, -1);
        checks++;
        if (err_after_start !== 1'b0) begin errors++; $display("FAIL early_error_clear: got %b required 0", err_after_start); end
        checks++;
        if (strobe_bad() !== 0 || done_cnt !== 1) begin errors++; $display("FAIL early_reload: %0d bad strobes done=%0d required 0 1", strobe_bad(), done_cnt); end
    endtask

    task automatic test_tlast_missing();
        fill_image(1'b1, -1);
        run_image(0, -1);
        checks++;
        if (strobe_bad() !== 0 || done_cnt !== 1) begin errors++; $display("FAIL missing_load: %0d bad strobes done=%0d required 0 1", strobe_bad(), done_cnt); end
        checks++;
        if (error !== exp_error) begin errors++; $display("FAIL missing_error: got %b required %b", error, exp_error); end
    endtask

    task automatic test_start_ignored();
        fill_image(1'b0, TOTAL - 1);
        run_image(0, 3);
        checks++;
        if (strobe_bad() !== 0) begin errors++; $display("FAIL start_ign_strobes: %0d bad, %0d observed required 0 bad of %0d", strobe_bad(), obs_q.size(), exp_q.size()); end
        checks++;
        if (done_cnt !== 1 || error !== 1'b0) begin errors++; $display("FAIL start_ign_done: done=%0d error=%b required 1 0", done_cnt, error); end
    endtask

    task automatic test_reset_mid_load();
        fill_image(1'b0, TOTAL - 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_tvalid = 1'b1; s_tdata = img[k];
            @(posedge clk); #1;
        end
        s_tdata = img[5];
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_tready, weightValid, biasValid, busy, done, error} !== 6'b0 ||
            {weightValue, biasValue, config_layer_num, config_neuron_num} !== '0) begin
            errors++; $display("FAIL midreset_outputs: flags=%b w=%h b=%h l=%h n=%h required all zero",
                {s_tready, weightValid, biasValid, busy, done, error}, weightValue, biasValue, config_layer_num, config_neuron_num);
        end
        s_tvalid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_image(0, -1);
        checks++;
        if (strobe_bad() !== 0 || done_cnt !== 1 || error !== 1'b0) begin
            errors++; $display("FAIL midreset_reload: %0d bad strobes done=%0d error=%b required 0 1 0", strobe_bad(), done_cnt, error);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int sel = $urandom_range(0, 2);
            fill_image(1'b0, (sel == 0) ? TOTAL - 1 : (sel == 1) ? int'($urandom_range(0, TOTAL - 2)) : -1);
            if (sel == 1) lst[TOTAL - 1] = 1'b1;
            run_image(2, -1);
            checks++;
            if (strobe_bad() !== 0 || addr_chg !== 0 || both_cnt !== 0) begin
                errors++; $display("FAIL rand%0d_strobes: %0d bad addr_chg=%0d both=%0d required 0 0 0", r, strobe_bad(), addr_chg, both_cnt);
            end
            checks++;
            if (done_cnt !== int'(exp_done) || error !== exp_error || busy !== 1'b0) begin
                errors++; $display("FAIL rand%0d_status: done=%0d error=%b busy=%b required %0d %b 0", r, done_cnt, error, busy, exp_done, exp_error);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_no_consume();
        test_back_to_back();
        test_gaps();
        test_tlast_early();
        test_tlast_missing();
        test_start_ignored();
        test_reset_mid_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
